// File: rtl/key_event_queue_pkg.sv
// key_evt_pkg: shared widths, key vector/code types and priority helpers for the key event queue.
package key_evt_pkg;
    localparam int NKEYS  = 6;
    localparam int CODE_W = 3;
    localparam int DEPTH  = 8;
    typedef logic [NKEYS-1:0]  key_vec_t;
    typedef logic [CODE_W-1:0] key_code_t;
    function automatic key_vec_t lsb_onehot(input key_vec_t v);
        return v & (~v + key_vec_t'(1));
    endfunction
    function automatic key_code_t onehot2code(input key_vec_t v);
        key_code_t c = '0;
        for (int i = 0; i < NKEYS; i++) c |= v[i] ? key_code_t'(i) : '0;
        return c;
    endfunction
endpackage

// File: rtl/key_event_queue_if.sv
// key_event_queue_if: valid/ready event port carrying key codes from the queue to its consumer.
interface key_event_queue_if
    import key_evt_pkg::*;
();
    logic      evt_valid;
    logic      evt_ready;
    key_code_t evt_code;
    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/key_event_queue_fifo.sv
// key_evt_fifo: first-word-fall-through FIFO with occupancy count; head reads as zero when empty.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 3,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic          valid,
    output logic          full,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) if (push) mem[wptr] <= din;
    assign valid = count != '0;
    assign full  = count == CW'(DEPTH);
    assign dout  = valid ? mem[rptr] : '0;
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: serialises key press pulses lowest-index first into a FIFO of key codes,
// with a sticky overflow flag for coalesced presses and a toggle-per-press LED vector.
module key_event_queue
    import key_evt_pkg::*;
#(
    parameter int DEPTH = key_evt_pkg::DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  key_vec_t            key_pulse,
    key_event_queue_if.master   evt,
    output logic [CW-1:0]       evt_count,
    output logic                overflow,
    input  logic                ovf_clr,
    output key_vec_t            led_state
);
    key_vec_t pending, grant;
    logic     pop, push, full;
    assign pop   = evt.evt_valid & evt.evt_ready;
    // a pop frees a slot in the same cycle, so a full queue can still accept a grant
    assign grant = (!full || pop) ? lsb_onehot(pending) : '0;
    assign push  = |grant;
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            overflow  <= 1'b0;
            led_state <= '0;
        end else begin
            pending   <= (pending & ~grant) | key_pulse;
            overflow  <= (|(key_pulse & pending & ~grant)) | (overflow & ~ovf_clr);
            led_state <= led_state ^ key_pulse;
        end
    end
    key_evt_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (onehot2code(grant)),
        .valid (evt.evt_valid),
        .full  (full),
        .dout  (evt.evt_code),
        .count (evt_count)
    );
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: scenario tasks with inline checks plus a scoreboard of expected popped codes.
module tb_key_event_queue;
    import key_evt_pkg::*;
    logic      clk = 1'b0;
    logic      rst, ovf_clr;
    key_vec_t  key_pulse, led_state, led_exp;
    logic [3:0] evt_count;
    logic      overflow;
    int        checks = 0, failures = 0, pops = 0;
    key_code_t exp_q[$];
    key_code_t exp_code;
    key_event_queue_if bus();
    key_event_queue dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .evt       (bus),
        .evt_count (evt_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .led_state (led_state)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst && bus.evt_valid && bus.evt_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%0d exp=none", bus.evt_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (bus.evt_code !== exp_code) begin
                    failures++;
                    $display("FAIL pop_code got=%0d exp=%0d", bus.evt_code, exp_code);
                end
            end
        end
    end
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(input key_vec_t k);
        key_pulse = k;
        led_exp ^= k;
        step(1);
        key_pulse = '0;
    endtask
    task automatic test_reset;
        rst = 1'b1; key_pulse = '0; ovf_clr = 1'b0; bus.evt_ready = 1'b0;
        step(2);
        rst = 1'b0; led_exp = '0;
        checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.evt_valid); end
        checks++; if (bus.evt_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", bus.evt_code); end
        checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (led_state !== 6'b0) begin failures++; $display("FAIL reset_led got=%b exp=000000", led_state); end
    endtask
    task automatic test_single;
        press(6'b000100); exp_q.push_back(3'd2);
        step(1);
        checks++; if (bus.evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.evt_valid); end
        checks++; if (bus.evt_code !== 3'd2) begin failures++; $display("FAIL single_code got=%0d exp=2", bus.evt_code); end
        checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", evt_count); end
        checks++; if (led_state !== 6'b000100) begin failures++; $display("FAIL single_led got=%b exp=000100", led_state); end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 50 && (bus.evt_valid || dut.pending != '0); i++) step(1);
        bus.evt_ready = 1'b0;
        checks++; if (bus.evt_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL single_drain got=valid%b/left%0d exp=valid0/left0", bus.evt_valid, exp_q.size()); end
    endtask
    task automatic test_two_keys;
        bus.evt_ready = 1'b1;
        press(6'b100001); exp_q.push_back(3'd0); exp_q.push_back(3'd5);
        step(1);
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_code !== 3'd0) begin failures++; $display("FAIL two_first got=%b/%0d exp=1/0", bus.evt_valid, bus.evt_code); end
        step(1);
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_code !== 3'd5) begin failures++; $display("FAIL two_second got=%b/%0d exp=1/5", bus.evt_valid, bus.evt_code); end
        step(1);
        checks++; if (bus.evt_valid !== 1'b0 || evt_count !== 4'd0) begin failures++; $display("FAIL two_empty got=%b/%0d exp=0/0", bus.evt_valid, evt_count); end
        checks++; if (led_state !== led_exp) begin failures++; $display("FAIL two_led got=%b exp=%b", led_state, led_exp); end
        bus.evt_ready = 1'b0;
    endtask
    task automatic test_overflow;
        int keys[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        int p0;
        bus.evt_ready = 1'b0;
        foreach (keys[j]) begin
            press(key_vec_t'(1) << keys[j]); exp_q.push_back(key_code_t'(keys[j]));
            step(2);
        end
        checks++; if (evt_count !== 4'd8) begin failures++; $display("FAIL ovf_fill_count got=%0d exp=8", evt_count); end
        press(6'b001000);
        step(3);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        press(6'b001000); exp_q.push_back(3'd3);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (dut.pending[3] !== 1'b1) begin failures++; $display("FAIL ovf_pending got=%b exp=1", dut.pending[3]); end
        p0 = pops;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 50 && (bus.evt_valid || dut.pending != '0); i++) step(1);
        bus.evt_ready = 1'b0;
        checks++; if (pops - p0 != 9 || exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain got=pops%0d/left%0d exp=pops9/left0", pops - p0, exp_q.size()); end
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask
    task automatic test_full_stream;
        int bad = 0;
        bus.evt_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            press(key_vec_t'(1) << (j % 6)); exp_q.push_back(key_code_t'(j % 6));
            step(2);
        end
        press(6'b010000); exp_q.push_back(3'd4);
        step(2);
        checks++; if (evt_count !== 4'd8 || dut.pending !== 6'b010000) begin failures++; $display("FAIL full_pre got=%0d/%b exp=8/010000", evt_count, dut.pending); end
        bus.evt_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            key_pulse = 6'b010000; led_exp ^= key_pulse; exp_q.push_back(3'd4);
            step(1);
            if (evt_count !== 4'd8) bad++;
        end
        key_pulse = '0;
        checks++; if (bad != 0) begin failures++; $display("FAIL full_count_hold got=%0d_cycles_off exp=0", bad); end
        for (int i = 0; i < 50 && (bus.evt_valid || dut.pending != '0); i++) step(1);
        bus.evt_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || overflow !== 1'b0) begin failures++; $display("FAIL full_drain got=left%0d/ovf%b exp=left0/ovf0", exp_q.size(), overflow); end
        checks++; if (led_state !== led_exp) begin failures++; $display("FAIL full_led got=%b exp=%b", led_state, led_exp); end
    endtask
    task automatic test_reset_flush;
        bus.evt_ready = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0; led_exp = '0; exp_q.delete();
        press(6'b000111);
        press(6'b000110);
        step(2);
        press(6'b000100); step(2);
        press(6'b010000); step(2);
        checks++; if (evt_count !== 4'd5 || overflow !== 1'b1 || led_state !== 6'b010101) begin failures++; $display("FAIL flush_pre got=%0d/%b/%b exp=5/1/010101", evt_count, overflow, led_state); end
        rst = 1'b1; step(1); rst = 1'b0; led_exp = '0; exp_q.delete();
        checks++; if (bus.evt_valid !== 1'b0 || bus.evt_code !== 3'd0 || evt_count !== 4'd0) begin failures++; $display("FAIL flush_fifo got=%b/%0d/%0d exp=0/0/0", bus.evt_valid, bus.evt_code, evt_count); end
        checks++; if (overflow !== 1'b0 || led_state !== 6'b0) begin failures++; $display("FAIL flush_state got=%b/%b exp=0/000000", overflow, led_state); end
        press(6'b000100); exp_q.push_back(3'd2);
        step(1);
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_code !== 3'd2 || evt_count !== 4'd1 || led_state !== 6'b000100) begin failures++; $display("FAIL flush_after got=%b/%0d/%0d/%b exp=1/2/1/000100", bus.evt_valid, bus.evt_code, evt_count, led_state); end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 50 && (bus.evt_valid || dut.pending != '0); i++) step(1);
        bus.evt_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL flush_drain got=left%0d exp=left0", exp_q.size()); end
    endtask
    task automatic test_ovf_clr_race;
        bus.evt_ready = 1'b1;
        press(6'b000011);
        press(6'b000010); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL race_set got=%b exp=1", overflow); end
        press(6'b000011);
        ovf_clr = 1'b1;
        press(6'b000010); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL race_set_wins got=%b exp=1", overflow); end
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL race_clear got=%b exp=0", overflow); end
        for (int i = 0; i < 50 && (bus.evt_valid || dut.pending != '0); i++) step(1);
        bus.evt_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || led_state !== led_exp) begin failures++; $display("FAIL race_drain got=left%0d/%b exp=left0/%b", exp_q.size(), led_state, led_exp); end
    endtask
    initial begin
        test_reset;
        test_single;
        test_two_keys;
        test_overflow;
        test_full_stream;
        test_reset_flush;
        test_ovf_clr_race;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
